// File: rtl/i2751_pkg.sv
// Shared types and constants for the i2751 sequence cell.
package i2751_pkg;

  localparam int unsigned PAIR_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    HIT  = 3'd4
  } mon_state_e;

  localparam logic [PAIR_W-1:0] PAT0 = 2'b00;
  localparam logic [PAIR_W-1:0] PAT1 = 2'b01;
  localparam logic [PAIR_W-1:0] PAT2 = 2'b10;
  localparam logic [PAIR_W-1:0] PAT3 = 2'b11;

endpackage

// File: rtl/i2751_seq_monitor.sv
// Watches the input pair for 00->01->10->11 and keeps an armed flag for a
// bounded number of cycles after each detection.
module i2751_seq_monitor
  import i2751_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAIR_W-1:0] pair,
  output logic              armed_next_c
);

  localparam int unsigned     CNT_W     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  mon_state_e       state_q, state_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             detect_c;

  // State, armed flag and hold counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a 00 in any state restarts the pattern at S0.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (pair == PAT0) ? S0 : IDLE;
      S0:      state_d = (pair == PAT1) ? S1 : ((pair == PAT0) ? S0 : IDLE);
      S1:      state_d = (pair == PAT2) ? S2 : ((pair == PAT0) ? S0 : IDLE);
      S2:      state_d = (pair == PAT3) ? HIT : ((pair == PAT0) ? S0 : IDLE);
      HIT:     state_d = (pair == PAT0) ? S0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Armed/counter update: detection arms in the same edge as the final 11
  // (the HIT state that follows just passes through), and reloads if already
  // armed. A zero hold keeps armed until reset.
  always_comb begin
    armed_d  = armed_q;
    cnt_d    = cnt_q;
    detect_c = (state_q == S2) && (pair == PAT3);
    if (detect_c) begin
      armed_d = 1'b1;
      cnt_d   = HOLD_LOAD;
    end else if (armed_q && (HOLD_CYCLES != 0)) begin
      if (cnt_q <= CNT_W'(1)) begin
        armed_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
    armed_next_c = armed_d;
  end

endmodule

// File: rtl/i2751_seq_cell.sv
// Registered XOR of two inputs with an optional, parameter-gated inversion
// driven by the sequence monitor.
module i2751_seq_cell
  import i2751_pkg::*;
#(
  parameter bit          TRIGGER_EN  = 1'b0,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic CK,
  input  logic reset,
  input  logic N0,
  input  logic N1,
  output logic output_single
);

  logic out_q, out_d;
  logic armed_next_c;

  i2751_seq_monitor #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_monitor (
    .clk          (CK),
    .rst          (reset),
    .pair         ({N0, N1}),
    .armed_next_c (armed_next_c)
  );

  // Golden XOR, inverted only when the payload is enabled and armed.
  always_comb begin
    out_d = (N0 ^ N1) ^ (TRIGGER_EN & armed_next_c);
  end

  // Output register.
  always_ff @(posedge CK) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign output_single = out_q;

endmodule

// File: tb/tb_i2751_seq_cell.sv
// Self-checking bench: four parameterisations driven by shared stimulus and
// compared against a pattern-window reference model.
module tb_i2751_seq_cell;

  logic CK;
  logic reset;
  logic N0;
  logic N1;
  logic o_te0;
  logic o_h4;
  logic o_h0;
  logic o_h1;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [1:0] hist[$];
  int         edge_idx;
  int         det_idx;
  bit         have_det;

  i2751_seq_cell #(.TRIGGER_EN(1'b0), .HOLD_CYCLES(4)) dut_te0 (
    .CK(CK), .reset(reset), .N0(N0), .N1(N1), .output_single(o_te0));
  i2751_seq_cell #(.TRIGGER_EN(1'b1), .HOLD_CYCLES(4)) dut_h4 (
    .CK(CK), .reset(reset), .N0(N0), .N1(N1), .output_single(o_h4));
  i2751_seq_cell #(.TRIGGER_EN(1'b1), .HOLD_CYCLES(0)) dut_h0 (
    .CK(CK), .reset(reset), .N0(N0), .N1(N1), .output_single(o_h0));
  i2751_seq_cell #(.TRIGGER_EN(1'b1), .HOLD_CYCLES(1)) dut_h1 (
    .CK(CK), .reset(reset), .N0(N0), .N1(N1), .output_single(o_h1));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Inversion is active while the most recent detection is less than
  // 'hold' edges old (forever when hold is zero).
  function automatic bit armed_exp(input int unsigned hold);
    if (!have_det) return 1'b0;
    if (hold == 0) return 1'b1;
    return (edge_idx - det_idx) < int'(hold);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_idx);
    end
  endtask

  // One clock: drive on the falling edge, update model, sample after rise.
  task automatic step(input bit r, input bit a, input bit b);
    logic x;
    @(negedge CK);
    reset = r;
    N0    = a;
    N1    = b;
    @(posedge CK);
    #1;
    edge_idx++;
    if (r) begin
      hist.delete();
      have_det = 1'b0;
    end else begin
      hist.push_back({a, b});
      if (hist.size() > 4) void'(hist.pop_front());
      if (hist.size() == 4 && hist[0] == 2'b00 && hist[1] == 2'b01 &&
          hist[2] == 2'b10 && hist[3] == 2'b11) begin
        have_det = 1'b1;
        det_idx  = edge_idx;
      end
    end
    x = r ? 1'b0 : (a ^ b);
    check("te0", o_te0, x);
    check("h4",  o_h4,  r ? 1'b0 : (x ^ armed_exp(4)));
    check("h0",  o_h0,  r ? 1'b0 : (x ^ armed_exp(0)));
    check("h1",  o_h1,  r ? 1'b0 : (x ^ armed_exp(1)));
  endtask

  task automatic pattern();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_idx = 0;
    det_idx  = 0;
    have_det = 1'b0;
    reset    = 1'b1;
    N0       = 1'b1;
    N1       = 1'b1;

    // Reset held with 11, then released with 11.
    step(1'b1, 1'b1, 1'b1);
    check("plan_rst", o_h4, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("plan_rel", o_h4, 1'b0);

    // Truth table / detection: 00 01 10 11.
    pattern();
    check("plan_golden_11", o_te0, 1'b0);
    check("plan_det_11",    o_h4,  1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    check("plan_hold_drop", o_h4, 1'b0);
    check("plan_hold0",     o_h0, 1'b1);

    // Broken pattern after reset.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("plan_broken", o_h4, 1'b0);

    // Restart via 00.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    pattern();
    check("plan_restart", o_h4, 1'b1);

    // Mid-sequence reset kills detection.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("plan_midrst", o_h4, 1'b0);

    // Back-to-back detections reload the hold counter.
    pattern();
    pattern();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Randomised traffic biased toward the trigger pattern.
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 39);
      if (sel == 0) begin
        step(1'b1, 1'($urandom), 1'($urandom));
      end else if (sel < 8) begin
        pattern();
      end else begin
        step(1'b0, 1'($urandom), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
